qspi_flash_reader: RTL and testbench
====================================

Name: qspi_flash_reader

Overview:
- Sequential SPI/QSPI read engine. Sits between the SoC flash read port and the four flash PADINOUT buffers plus the flash_csb and flash_clk outputs.
- Accepts one 24-bit byte-address read request at a time. Issues a Read (0x03) or Fast Read Quad Output (0x6B) transaction to the external flash. Returns one 32-bit word.
- Drives the pad-side DO and OEN signals directly. OEN is active-low, as on the pads.

Parameters:
- CLK_DIV, 1, number of pll_clk cycles per flash_clk half-period; legal range 1..15.
- DUMMY_CYCLES, 8, number of flash_clk cycles between address and data in quad mode.

Ports:
- pll_clk  input  1  system clock; all state on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  read request valid.
- req_ready  output  1  engine idle; a request is accepted when req_valid && req_ready.
- req_addr  input  24  flash byte address; sampled at acceptance.
- quad_en  input  1  1 = quad read (0x6B), 0 = single read (0x03); sampled at acceptance.
- rsp_valid  output  1  one-cycle pulse; rsp_rdata is valid in that cycle.
- rsp_rdata  output  32  read word, little-endian: first flash byte in [7:0].
- flash_csb  output  1  flash chip select, active-low.
- flash_clk  output  1  SPI clock, mode 0 (idles low).
- flash_io_do  output  4  pad DO for io3..io0.
- flash_io_oeb  output  4  pad OEN for io3..io0; 0 = drive.
- flash_io_di  input  4  pad DI for io3..io0.

Behaviour:
- Reset (asynchronous on resetn low) forces:
  - flash_csb=1, flash_clk=0, flash_io_do=4'b1100, flash_io_oeb=4'b0010;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, state=IDLE.
- req_ready rises on the first pll_clk edge after resetn deasserts.
- Reset asserted mid-transaction aborts immediately. flash_csb goes high asynchronously. No rsp_valid is produced.
- io2/io3 (WP#/HOLD#) are driven high in every state except quad DUMMY and DATA, where they are released.
- States and pin behaviour:
  - IDLE: req_ready=1, csb=1, clk=0. On acceptance at edge T: latch addr and mode, go to CMD. csb goes low at T+1.
  - CMD: shift the 8-bit opcode MSB-first on io0 (oeb[0]=0). io1 is an input.
  - ADDR: shift req_addr[23:0] MSB-first on io0.
  - DUMMY (quad only): DUMMY_CYCLES flash_clk periods; all oeb=1.
  - DATA: single mode shifts 32 bits from io1, MSB-first within each byte. Quad mode reads 8 nibbles from io[3:0], high nibble first within each byte, all oeb=1.
  - DONE: csb=1, clk=0, rsp_valid pulses for one cycle. Hold csb high for 2*CLK_DIV cycles, then go to IDLE.
- Clocking: each flash_clk period is 2*CLK_DIV pll_clk cycles, low phase first.
  - DO changes only at the start of the low phase.
  - DI is sampled on the pll_clk edge that ends each high phase.
- Latency (N = 64 single, 40+DUMMY_CYCLES quad):
  - rsp_valid is high in cycle T+1+N*2*CLK_DIV.
  - req_ready re-asserts at rsp_valid cycle + 2*CLK_DIV.
- rsp_rdata holds its value until the next response.
- Address is transmitted as latched. No wrap logic: 0xFFFFFF followed by flash-internal wrap is the flash's concern.
- req_valid during a transaction is ignored (req_ready=0). Input changes after acceptance have no effect.
- rsp_valid and a new acceptance never coincide.

Test Plan:
- Single read, CLK_DIV=1, addr 0x000100, model returns A5,5A,3C,C3 ->
  - io0 carries 0x03 then 0x000100;
  - rsp_rdata=0xC33C5AA5 with rsp_valid at T+129;
  - req_ready returns at T+131.
- Quad read, CLK_DIV=1, DUMMY_CYCLES=8, addr 0x123456, model returns 12,34,56,78 ->
  - opcode 0x6B;
  - oeb=4'b1111 during dummy and data;
  - rsp_rdata=0x78563412 at T+97.
- CLK_DIV=3, single read ->
  - flash_clk period is 6 cycles, low phase first;
  - rsp_valid at T+385;
  - DO is stable across every rising flash_clk.
- Back-to-back: req_valid held high with two addresses ->
  - second acceptance exactly 2*CLK_DIV cycles after the first rsp_valid;
  - csb high for at least 2*CLK_DIV cycles between transactions.
- Reset pulse during ADDR ->
  - csb=1, clk=0, oeb=4'b0010, no rsp_valid;
  - after release, a new read completes correctly.
- Edge address 0xFFFFFF in quad mode ->
  - 24 ones shifted on io0;
  - data assembled per the byte and nibble ordering rules.

Source files
------------

// File: rtl/qspi_flash_reader.sv
// rtl/qspi_flash_reader.sv - SPI/QSPI single-word flash read engine
//
// Accepts one 24-bit byte-address read at a time, runs a Read (0x03) or
// Fast Read Quad Output (0x6B) transaction on the flash pads and returns
// one little-endian 32-bit word.
//
// Ports:
//   pll_clk       system clock, all state on its rising edge
//   resetn        asynchronous active-low reset
//   req_valid     read request valid
//   req_ready     engine idle; request accepted on req_valid && req_ready
//   req_addr      flash byte address, sampled at acceptance
//   quad_en       1 = quad read (0x6B), 0 = single read (0x03)
//   rsp_valid     one-cycle pulse, rsp_rdata valid in that cycle
//   rsp_rdata     read word, first flash byte in [7:0]
//   flash_csb     flash chip select, active-low
//   flash_clk     SPI clock, mode 0
//   flash_io_do   pad DO for io3..io0
//   flash_io_oeb  pad OEN for io3..io0, 0 = drive
//   flash_io_di   pad DI for io3..io0
module qspi_flash_reader #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned DUMMY_CYCLES = 8
) (
  input  logic        pll_clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        quad_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic [3:0]  flash_io_do,
  output logic [3:0]  flash_io_oeb,
  input  logic [3:0]  flash_io_di
);

  // Position within one flash_clk period, counted in pll_clk cycles.
  localparam logic [4:0] HALF_LAST   = 5'(CLK_DIV - 1);
  localparam logic [4:0] PERIOD_LAST = 5'(2 * CLK_DIV - 1);
  localparam logic [7:0] DUMMY_LAST  = 8'(DUMMY_CYCLES - 1);
  localparam bit         HAS_DUMMY   = (DUMMY_CYCLES != 0);

  // io3/io2 (HOLD#/WP#) held high, io1 is the single-mode data input.
  localparam logic [3:0] DO_IDLE  = 4'b1100;
  localparam logic [3:0] OEB_IDLE = 4'b0010;
  localparam logic [3:0] OEB_QUAD = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cyc_q, cyc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        quad_q, quad_d;
  // Bits still to be sent after the one currently on io0.
  logic [30:0] sout_q, sout_d;
  logic [30:0] sin_q, sin_d;

  logic        ready_d, valid_d, csb_d, sclk_d;
  logic [31:0] rdata_d;
  logic [3:0]  do_d, oeb_d;

  logic [7:0]  opcode;
  logic [31:0] sin_shift;
  logic [7:0]  data_last;

  assign opcode    = quad_en ? 8'h6B : 8'h03;
  assign sin_shift = quad_q ? {sin_q[27:0], flash_io_di} : {sin_q, flash_io_di[1]};
  assign data_last = quad_q ? 8'd7 : 8'd31;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    quad_d  = quad_q;
    sout_d  = sout_q;
    sin_d   = sin_q;
    ready_d = req_ready;
    valid_d = 1'b0;
    rdata_d = rsp_rdata;
    csb_d   = flash_csb;
    sclk_d  = flash_clk;
    do_d    = flash_io_do;
    oeb_d   = flash_io_oeb;

    unique case (state_q)
      S_IDLE: begin
        if (!req_ready) begin
          ready_d = 1'b1;
        end else if (req_valid) begin
          state_d = S_CMD;
          ready_d = 1'b0;
          quad_d  = quad_en;
          sout_d  = {opcode[6:0], req_addr};
          do_d    = {DO_IDLE[3:1], opcode[7]};
          csb_d   = 1'b0;
          cyc_d   = '0;
          cnt_d   = '0;
        end
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        cyc_d = cyc_q + 5'd1;
        if (cyc_q == HALF_LAST) begin
          sclk_d = 1'b1;
        end
        // End of the high phase: sample DI, drop the clock and present the
        // next DO bit so it is stable for the whole following period.
        if (cyc_q == PERIOD_LAST) begin
          cyc_d   = '0;
          sclk_d  = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          do_d[0] = sout_q[30];
          sout_d  = {sout_q[29:0], 1'b0};
          case (state_q)
            S_CMD: begin
              if (cnt_q == 8'd7) begin
                state_d = S_ADDR;
                cnt_d   = '0;
              end
            end
            S_ADDR: begin
              if (cnt_q == 8'd23) begin
                cnt_d = '0;
                if (quad_q) begin
                  oeb_d   = OEB_QUAD;
                  state_d = HAS_DUMMY ? S_DUMMY : S_DATA;
                end else begin
                  state_d = S_DATA;
                end
              end
            end
            S_DUMMY: begin
              if (cnt_q == DUMMY_LAST) begin
                state_d = S_DATA;
                cnt_d   = '0;
              end
            end
            S_DATA: begin
              sin_d = sin_shift[30:0];
              if (cnt_q == data_last) begin
                state_d = S_DONE;
                cnt_d   = '0;
                valid_d = 1'b1;
                // Bytes arrive first-byte-first in the top of the shifter.
                rdata_d = {sin_shift[7:0], sin_shift[15:8],
                           sin_shift[23:16], sin_shift[31:24]};
                csb_d   = 1'b1;
                do_d    = DO_IDLE;
                oeb_d   = OEB_IDLE;
              end
            end
            default: ;
          endcase
        end
      end

      // Chip-select deselect time before the next command may start.
      S_DONE: begin
        if (cyc_q == PERIOD_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pll_clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      cnt_q        <= '0;
      quad_q       <= 1'b0;
      sout_q       <= '0;
      sin_q        <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      flash_csb    <= 1'b1;
      flash_clk    <= 1'b0;
      flash_io_do  <= DO_IDLE;
      flash_io_oeb <= OEB_IDLE;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      cnt_q        <= cnt_d;
      quad_q       <= quad_d;
      sout_q       <= sout_d;
      sin_q        <= sin_d;
      req_ready    <= ready_d;
      rsp_valid    <= valid_d;
      rsp_rdata    <= rdata_d;
      flash_csb    <= csb_d;
      flash_clk    <= sclk_d;
      flash_io_do  <= do_d;
      flash_io_oeb <= oeb_d;
    end
  end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// tb/tb_qspi_flash_reader.sv - bench for qspi_flash_reader with a behavioural flash model
module tb_qspi_flash_reader;

  localparam int DUMMY = 8;

  logic pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  // Index 0: CLK_DIV=1, index 1: CLK_DIV=3.
  logic        resetn    [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [23:0] req_addr  [2];
  logic        quad_en   [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        flash_csb [2];
  logic        flash_clk [2];
  logic [3:0]  io_do     [2];
  logic [3:0]  io_oeb    [2];
  logic [3:0]  io_di     [2];

  qspi_flash_reader #(.CLK_DIV(1), .DUMMY_CYCLES(DUMMY)) u_div1 (
    .pll_clk(pll_clk), .resetn(resetn[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .quad_en(quad_en[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .flash_csb(flash_csb[0]), .flash_clk(flash_clk[0]),
    .flash_io_do(io_do[0]), .flash_io_oeb(io_oeb[0]), .flash_io_di(io_di[0])
  );

  qspi_flash_reader #(.CLK_DIV(3), .DUMMY_CYCLES(DUMMY)) u_div3 (
    .pll_clk(pll_clk), .resetn(resetn[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .quad_en(quad_en[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .flash_csb(flash_csb[1]), .flash_clk(flash_clk[1]),
    .flash_io_do(io_do[1]), .flash_io_oeb(io_oeb[1]), .flash_io_di(io_di[1])
  );

  int cyc = 0;
  always @(posedge pll_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Flash model state: periods counted from chip-select fall.
  logic [31:0] flash_word [2];
  logic [31:0] cap        [2];
  logic [3:0]  do_rise    [2];
  logic        prev_clk   [2] = '{1'b0, 1'b0};
  logic        prev_csb   [2] = '{1'b1, 1'b1};
  bit          is_quad    [2] = '{1'b0, 1'b0};
  int rise_n   [2] = '{0, 0};
  int fall_n   [2] = '{0, 0};
  int hi_run   [2] = '{0, 0};
  int last_gap [2] = '{0, 0};
  int stab_err [2] = '{0, 0};
  int pin_err  [2] = '{0, 0};
  int rsp_cnt  [2] = '{0, 0};

  // DI the flash presents during period p: byte i of flash_word is the
  // i-th byte read out, MSB first (single) or high nibble first (quad).
  function automatic logic [3:0] model_di(input int k, input int p);
    int j;
    logic [7:0] b;
    logic [3:0] v;
    v = 4'($urandom);
    j = p - (is_quad[k] ? 32 + DUMMY : 32);
    if (is_quad[k] && j >= 0 && j < 8) begin
      b = flash_word[k][8*(j/2) +: 8];
      v = (j % 2 == 0) ? b[7:4] : b[3:0];
    end else if (!is_quad[k] && j >= 0 && j < 32) begin
      b = flash_word[k][8*(j/8) +: 8];
      v[1] = b[7 - (j % 8)];
    end
    return v;
  endfunction

  always @(negedge pll_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rsp_valid[k] === 1'b1) rsp_cnt[k]++;
      if (flash_csb[k] !== 1'b0) begin
        hi_run[k]++;
      end else begin
        if (prev_csb[k]) begin
          last_gap[k] = hi_run[k];
          hi_run[k]   = 0;
          rise_n[k]   = 0;
          fall_n[k]   = 0;
          cap[k]      = '0;
          is_quad[k]  = 1'b0;
          io_di[k]    = 4'($urandom);
        end
        if (flash_clk[k] && !prev_clk[k]) begin
          if (rise_n[k] < 32) cap[k] = {cap[k][30:0], io_do[k][0]};
          if (rise_n[k] == 7) is_quad[k] = (cap[k][7:0] == 8'h6B);
          if (is_quad[k] && rise_n[k] >= 32) begin
            if (io_oeb[k] !== 4'b1111) pin_err[k]++;
          end else if (io_oeb[k] !== 4'b0010 || io_do[k][3:2] !== 2'b11) begin
            pin_err[k]++;
          end
          do_rise[k] = io_do[k];
          rise_n[k]++;
        end else if (flash_clk[k] && prev_clk[k]) begin
          if (io_do[k] !== do_rise[k]) stab_err[k]++;
        end else if (!flash_clk[k] && prev_clk[k]) begin
          fall_n[k]++;
          io_di[k] = model_di(k, fall_n[k]);
        end
      end
      prev_clk[k] = flash_clk[k];
      prev_csb[k] = flash_csb[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int k);
    int t0;
    t0 = cyc;
    while (req_ready[k] !== 1'b1 && cyc - t0 < 2000) @(negedge pll_clk);
  endtask

  task automatic do_read(input int k, input logic [23:0] addr, input logic q,
                         input logic [31:0] word);
    int d2, n, t, s0, p0;
    d2 = (k == 0) ? 2 : 6;
    n  = q ? 40 + DUMMY : 64;
    flash_word[k] = word;
    s0 = stab_err[k];
    p0 = pin_err[k];
    wait_ready(k);
    chk($sformatf("ready_before_req[%0d]", k), 64'(req_ready[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    quad_en[k]   = q;
    t = cyc + 1;
    @(negedge pll_clk);
    req_valid[k] = 1'b0;
    req_addr[k]  = 24'($urandom);
    quad_en[k]   = 1'($urandom);
    chk($sformatf("csb_low_after_accept[%0d]", k), {flash_csb[k], req_ready[k]}, 64'd0);
    while (rsp_valid[k] !== 1'b1 && cyc - t < 4000) @(negedge pll_clk);
    chk($sformatf("rsp_latency[%0d]", k), 64'(cyc - t), 64'(n * d2));
    chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], word);
    chk($sformatf("cmd_addr_io0[%0d]", k), cap[k], {(q ? 8'h6B : 8'h03), addr});
    chk($sformatf("done_pins[%0d]", k), {flash_csb[k], flash_clk[k], io_oeb[k]}, 64'b1_0_0010);
    @(negedge pll_clk);
    chk($sformatf("rsp_pulse_hold[%0d]", k), {rsp_valid[k], rsp_rdata[k]}, {1'b0, word});
    while (req_ready[k] !== 1'b1 && cyc - t < 5000) @(negedge pll_clk);
    chk($sformatf("ready_return[%0d]", k), 64'(cyc - t), 64'(n * d2 + d2));
    chk($sformatf("pin_rules[%0d]", k), {32'(stab_err[k] - s0), 32'(pin_err[k] - p0)}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] a1, a2;
    logic [31:0] w1, w2;
    int r, t, n0;

    for (int k = 0; k < 2; k++) begin
      resetn[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = '0;
      quad_en[k] = 1'b0; flash_word[k] = '0;
    end
    repeat (3) @(negedge pll_clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_pins[%0d]", k),
          {flash_csb[k], flash_clk[k], io_do[k], io_oeb[k]}, 64'b1_0_1100_0010);
      chk($sformatf("reset_rsp[%0d]", k), {req_ready[k], rsp_valid[k], rsp_rdata[k]}, 64'd0);
      resetn[k] = 1'b1;
    end
    @(negedge pll_clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("ready_after_reset[%0d]", k), 64'(req_ready[k]), 64'd1);

    // Directed reads.
    do_read(0, 24'h000100, 1'b0, 32'hC33C5AA5);
    do_read(0, 24'h123456, 1'b1, 32'h78563412);
    do_read(1, 24'h000100, 1'b0, $urandom);
    do_read(1, 24'($urandom), 1'b1, $urandom);
    do_read(0, 24'hFFFFFF, 1'b1, $urandom);

    // Back-to-back with req_valid held high.
    a1 = 24'($urandom); a2 = 24'($urandom);
    w1 = $urandom;      w2 = $urandom;
    flash_word[0] = w1;
    wait_ready(0);
    req_valid[0] = 1'b1; req_addr[0] = a1; quad_en[0] = 1'b0;
    t = cyc + 1;
    @(negedge pll_clk);
    req_addr[0] = a2;
    while (rsp_valid[0] !== 1'b1 && cyc - t < 4000) @(negedge pll_clk);
    r = cyc;
    chk("b2b_first_rdata", rsp_rdata[0], w1);
    chk("b2b_first_addr", cap[0], {8'h03, a1});
    flash_word[0] = w2;
    @(negedge pll_clk);
    while (flash_csb[0] !== 1'b0 && cyc - r < 100) @(negedge pll_clk);
    chk("b2b_accept_delay", 64'(cyc - r), 64'd3);
    req_valid[0] = 1'b0;
    @(negedge pll_clk);
    chk("b2b_csb_gap", 64'(last_gap[0] >= 2), 64'd1);
    while (rsp_valid[0] !== 1'b1 && cyc - r < 4000) @(negedge pll_clk);
    chk("b2b_second_rdata", rsp_rdata[0], w2);
    chk("b2b_second_addr", cap[0], {8'h03, a2});

    // Reset pulse during the address phase.
    flash_word[0] = $urandom;
    wait_ready(0);
    req_valid[0] = 1'b1; req_addr[0] = 24'($urandom); quad_en[0] = 1'b0;
    @(negedge pll_clk);
    req_valid[0] = 1'b0;
    n0 = rsp_cnt[0];
    repeat (20) @(negedge pll_clk);
    #2 resetn[0] = 1'b0;
    #1;
    chk("abort_pins", {flash_csb[0], flash_clk[0], io_do[0], io_oeb[0]}, 64'b1_0_1100_0010);
    chk("abort_rsp", {req_ready[0], rsp_valid[0], rsp_rdata[0]}, 64'd0);
    repeat (3) @(negedge pll_clk);
    resetn[0] = 1'b1;
    @(negedge pll_clk);
    chk("abort_ready", 64'(req_ready[0]), 64'd1);
    repeat (5) @(negedge pll_clk);
    chk("abort_no_rsp", 64'(rsp_cnt[0] - n0), 64'd0);
    do_read(0, 24'($urandom), 1'b0, $urandom);

    // Randomized reads on both dividers.
    for (int i = 0; i < 6; i++)
      do_read(int'($urandom_range(0, 1)), 24'($urandom), 1'($urandom), $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
